axi4_master_port: RTL and testbench
===================================

# axi4_master_port

AXI4 master-side bridge: converts a simple single-request load/store/refill interface into AXI4 read and write transactions, one outstanding transaction at a time. It sits between the core's memory stage or cache-refill logic and the `io_master_*` bus that leaves the core. It is the initiator counterpart of the simulation memory/peripheral responder.

## Interface
Parameters:
- `ID`, 0: value driven on `awid` / `arid`.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge idle, accepts request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_len`  in  8  read beats minus 1; ignored for writes (always 1 beat).
- `req_size`  in  3  AXI size encoding (0/1/2).
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  write byte strobes.
- `rsp_valid`  out  1  read beat or write completion available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  32  read data; 0 for write completions.
- `rsp_last`  out  1  final response of the transaction.
- `rsp_err`  out  1  `rresp`/`bresp` ≠ 0, or burst-length mismatch.
- AXI AW channel: `awready` in 1; `awvalid` out 1; `awaddr` out 32; `awid` out 4; `awlen` out 8; `awsize` out 3; `awburst` out 2.
- AXI W channel: `wready` in 1; `wvalid` out 1; `wdata` out 32; `wstrb` out 4; `wlast` out 1.
- AXI B channel: `bready` out 1; `bvalid` in 1; `bresp` in 2; `bid` in 4.
- AXI AR channel: `arready` in 1; `arvalid` out 1; `araddr` out 32; `arid` out 4; `arlen` out 8; `arsize` out 3; `arburst` out 2.
- AXI R channel: `rready` out 1; `rvalid` in 1; `rdata` in 32; `rresp` in 2; `rlast` in 1; `rid` in 4.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the request is registered: `addr`, `len`, `size`, `wdata`, `wstrb`.
  - Next state is RADDR (read) or WADDR (write).
- RADDR:
  - `arvalid`=1, `araddr`=registered address, `arlen`=registered `len`, `arsize`=registered `size`, `arburst`=2'b01 (INCR), `arid`=`ID`.
  - Address, length, size, burst and ID are held stable until `arvalid & arready`; then go to RDATA.
  - Beat counter loaded with `len`.
- RDATA:
  - `rready`=`rsp_ready`; `rsp_valid`=`rvalid`; `rsp_data`=`rdata`; `rsp_last`=`rlast`. All pass-through, combinational.
  - Each `rvalid & rready` decrements the counter.
  - `rsp_err` = (`rresp` ≠ 0) | (`rlast` ≠ (counter == 0)).
  - The beat with `rlast` → IDLE.
- WADDR:
  - `awvalid`=1 and `wvalid`=1 are asserted together. `awlen`=0, `awburst`=2'b01, `wlast`=1.
  - Separate `aw_done` / `w_done` flags record each handshake; each valid drops the cycle after its own handshake.
  - When both are done (same or different cycles) → WRESP.
- WRESP:
  - `bready`=`rsp_ready`; `rsp_valid`=`bvalid`; `rsp_last`=1; `rsp_data`=0; `rsp_err`=(`bresp` ≠ 0).
  - Handshake → IDLE.
- `rid` and `bid` are ignored; single outstanding transaction only.
- Reset at any point, including mid-burst, forces IDLE and clears all valid/ready outputs and the done flags. The slave must be reset together with this block.

## Timing
- Reset values:
  - `req_ready`=0 while `reset`=1, then 1 from the first cycle in IDLE.
  - `awvalid`, `wvalid`, `arvalid`, `rready`, `bready`, `rsp_valid`=0.
  - All address/data outputs are 0.
- All AXI valids are registered. A request accepted in cycle N presents `arvalid`/`awvalid` in cycle N+1.
- `req_ready` is 0 in every state except IDLE. The next request can be accepted in the cycle after the last response handshake.
- A valid, once asserted, is never withdrawn before its handshake. Its payload is stable while the valid is high.
- Minimum read latency against a zero-wait slave: `req` N, `ar` handshake N+1, first `rsp` N+2.
- The R beat handshake and `rsp` handshake are the same event; there is no buffering.

## Structure
- Shared package `axi_pkg`:
  - burst encodings FIXED/INCR/WRAP;
  - resp codes OKAY/EXOKAY/SLVERR/DECERR;
  - size encodings;
  - state enum for this block.
- Single flat module. The beat counter and done flags are inline; no sub-module.

## Test plan
- Single-beat read, `addr` 0x80000000, `len`=0, responder returns 0xDEADBEEF with `rlast`=1 → exactly one `rsp` carrying 0xDEADBEEF, `rsp_last`=1, `rsp_err`=0; `arlen`=0 and `arburst`=01 on the bus.
- 4-beat refill, `addr` 0x80001000, `len`=3, with `rsp_ready` toggling 1,0,1,0 → 4 beats delivered in order, no beat lost or duplicated, `rsp_last` only on the 4th, `arvalid` high for exactly one handshake.
- Write 0x12345678, strobe 4'b0011, to 0xA00003F8, with `awready` delayed 2 cycles and `wready` immediate → W handshake first, AW 2 cycles later, then `bready` → one `rsp` with `rsp_last`=1 and `req_ready` back high.
- `bresp`=SLVERR on a write; separately `rlast` early on beat 2 of a `len`=3 read → `rsp_err`=1 on that response, and the FSM returns to IDLE.
- `reset` asserted during RDATA of an 8-beat burst → all valids 0 in the next cycle, `req_ready`=1 after reset drops, and a following single read completes normally.
- Back-to-back `req_valid` held high for read then write → the second request is accepted only in the cycle after the first `rsp_last` handshake.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the state type of the master-side bridge.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4
    } state_e;

endpackage

// File: rtl/axi4_master_port_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between the bridge and its responder.
interface axi4_master_port_if;

    logic        awready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        input  awready, output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wready,  output wvalid, wdata, wstrb, wlast,
        output bready,  input  bvalid, bresp, bid,
        input  arready, output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,  input  rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        output awready, input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output wready,  input  wvalid, wdata, wstrb, wlast,
        input  bready,  output bvalid, bresp, bid,
        output arready, input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,  output rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/axi4_master_port.sv
// Single-outstanding AXI4 master bridge: one load/store/refill request at a
// time turned into an AR+R burst or a single-beat AW+W+B write.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_RADDR | arvalid held with the registered request until arready
// ST_RDATA | R beats passed straight through to rsp, counting down
// ST_WADDR | awvalid/wvalid raised together, each drops after its handshake
// ST_WRESP | B response passed through to rsp
module axi4_master_port
    import axi_pkg::*;
#(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [7:0]                req_len,
    input  logic [2:0]                req_size,
    input  logic [31:0]               req_wdata,
    input  logic [3:0]                req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_data,
    output logic                      rsp_last,
    output logic                      rsp_err,
    axi4_master_port_if.master        axi
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;

    // IDs are not checked: only one transaction is ever in flight.
    logic unused_ids;
    assign unused_ids = ^{axi.bid, axi.rid};

    // Valids and payloads come straight from flops so they are glitch-free.
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arid    = ID;
    assign axi.arlen   = len_q;
    assign axi.arsize  = size_q;
    assign axi.arburst = BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awid    = ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = size_q;
    assign axi.awburst = BURST_INCR;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wvalid_q;

    assign ar_hs = arvalid_q & axi.arready;
    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;
    assign r_hs  = axi.rvalid & axi.rready;
    assign b_hs  = axi.bvalid & axi.bready;

    // State and request registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            beat_cnt_q <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            beat_cnt_q <= beat_cnt_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Response side is combinational pass-through; nothing is buffered.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_last   = 1'b0;
        rsp_err    = 1'b0;
        axi.rready = 1'b0;
        axi.bready = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: req_ready = 1'b1;
                ST_RDATA: begin
                    axi.rready = rsp_ready;
                    rsp_valid  = axi.rvalid;
                    rsp_data   = axi.rdata;
                    rsp_last   = axi.rlast;
                    rsp_err    = (axi.rresp != RESP_OKAY) |
                                 (axi.rlast != (beat_cnt_q == 8'd0));
                end
                ST_WRESP: begin
                    axi.bready = rsp_ready;
                    rsp_valid  = axi.bvalid;
                    rsp_last   = 1'b1;
                    rsp_err    = (axi.bresp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic, request capture and handshake bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        beat_cnt_d = beat_cnt_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                if (ar_hs) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = len_q;
                    state_d    = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - 8'd1;
                    if (axi.rlast) state_d = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_master_port.sv
// Directed cycle-accurate bench for axi4_master_port; the bench plays the
// AXI responder and the request/response consumer.
module tb_axi4_master_port;
    import axi_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_master_port_if bus();

    axi4_master_port #(.ID(4'd0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .axi       (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid  = 1'b0; bus.bresp  = 2'b00; bus.bid = 4'd0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0; bus.rdata  = '0; bus.rresp = 2'b00;
        bus.rlast   = 1'b0; bus.rid    = 4'd0;
    endtask

    task automatic req_issue(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        req_size  = SIZE_4B; req_wdata = wdata; req_wstrb = wstrb;
        #1;
        chk("req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic read_single(input logic [31:0] addr, input logic [31:0] data);
        req_issue(1'b0, addr, 8'd0, 32'd0, 4'd0);
        bus.arready = 1'b1;
        #1;
        chk("rd_arvalid", bus.arvalid, 1);
        chk("rd_araddr", bus.araddr, addr);
        chk("rd_arlen", bus.arlen, 0);
        chk("rd_arburst", bus.arburst, 1);
        chk("rd_arid", bus.arid, 0);
        chk("rd_req_busy", req_ready, 0);
        step();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = data; bus.rlast = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("rd_arvalid_drop", bus.arvalid, 0);
        chk("rd_rready", bus.rready, 1);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, data);
        chk("rd_rsp_last", rsp_last, 1);
        chk("rd_rsp_err", rsp_err, 0);
        step();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        #1;
        chk("rd_rsp_gone", rsp_valid, 0);
        chk("rd_back_idle", req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int beat;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_size = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        bus_idle();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // single-beat read
        read_single(32'h8000_0000, 32'hDEAD_BEEF);

        // 4-beat refill, AR stalled one cycle, rsp_ready toggling
        req_issue(1'b0, 32'h8000_1000, 8'd3, 32'd0, 4'd0);
        #1;
        chk("rf_arvalid_stall", bus.arvalid, 1);
        step();
        bus.arready = 1'b1;
        #1;
        chk("rf_arvalid_held", bus.arvalid, 1);
        chk("rf_araddr", bus.araddr, 32'h8000_1000);
        chk("rf_arlen", bus.arlen, 3);
        step();
        bus.arready = 1'b0;
        beat = 0;
        for (int i = 0; i < 7; i++) begin
            rsp_ready = (i % 2 == 0);
            bus.rvalid = 1'b1;
            bus.rdata = 32'h1000_0000 + beat;
            bus.rlast = (beat == 3);
            #1;
            chk("rf_arvalid_low", bus.arvalid, 0);
            chk("rf_rready", bus.rready, rsp_ready);
            chk("rf_data", rsp_data, 32'h1000_0000 + beat);
            chk("rf_last", rsp_last, beat == 3);
            chk("rf_err", rsp_err, 0);
            chk("rf_req_busy", req_ready, 0);
            if (rsp_ready) beat++;
            step();
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("rf_back_idle", req_ready, 1);

        // write: W immediate, AW two cycles later
        req_issue(1'b1, 32'hA000_03F8, 8'd0, 32'h1234_5678, 4'b0011);
        bus.wready = 1'b1;
        #1;
        chk("wr_awvalid", bus.awvalid, 1);
        chk("wr_wvalid", bus.wvalid, 1);
        chk("wr_awaddr", bus.awaddr, 32'hA000_03F8);
        chk("wr_awlen", bus.awlen, 0);
        chk("wr_awburst", bus.awburst, 1);
        chk("wr_wdata", bus.wdata, 32'h1234_5678);
        chk("wr_wstrb", bus.wstrb, 4'b0011);
        chk("wr_wlast", bus.wlast, 1);
        step();
        bus.wready = 1'b0;
        #1;
        chk("wr_wvalid_drop", bus.wvalid, 0);
        chk("wr_awvalid_wait1", bus.awvalid, 1);
        step();
        bus.awready = 1'b1;
        #1;
        chk("wr_awvalid_wait2", bus.awvalid, 1);
        chk("wr_bready_early", bus.bready, 0);
        step();
        bus.awready = 1'b0; bus.bvalid = 1'b1; bus.bresp = RESP_OKAY;
        #1;
        chk("wr_awvalid_drop", bus.awvalid, 0);
        chk("wr_bready", bus.bready, 1);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_last", rsp_last, 1);
        chk("wr_rsp_data", rsp_data, 0);
        chk("wr_rsp_err", rsp_err, 0);
        step();
        bus.bvalid = 1'b0;
        #1;
        chk("wr_back_idle", req_ready, 1);

        // write with SLVERR
        req_issue(1'b1, 32'h0000_0010, 8'd0, 32'hCAFE_F00D, 4'hF);
        bus.awready = 1'b1; bus.wready = 1'b1;
        #1;
        chk("se_awvalid", bus.awvalid, 1);
        chk("se_wvalid", bus.wvalid, 1);
        step();
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b1; bus.bresp = RESP_SLVERR;
        #1;
        chk("se_both_dropped", {bus.awvalid, bus.wvalid}, 0);
        chk("se_rsp_valid", rsp_valid, 1);
        chk("se_rsp_err", rsp_err, 1);
        step();
        bus.bvalid = 1'b0; bus.bresp = RESP_OKAY;
        #1;
        chk("se_back_idle", req_ready, 1);

        // read len=3 with rlast on beat 2
        req_issue(1'b0, 32'h8000_2000, 8'd3, 32'd0, 4'd0);
        bus.arready = 1'b1;
        #1;
        step();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA0; bus.rlast = 1'b0;
        #1;
        chk("el_beat0_err", rsp_err, 0);
        step();
        bus.rdata = 32'hA1; bus.rlast = 1'b1;
        #1;
        chk("el_beat1_data", rsp_data, 32'hA1);
        chk("el_beat1_err", rsp_err, 1);
        step();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        #1;
        chk("el_back_idle", req_ready, 1);

        // reset in the middle of an 8-beat burst
        req_issue(1'b0, 32'h8000_3000, 8'd7, 32'd0, 4'd0);
        bus.arready = 1'b1;
        #1;
        step();
        bus.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.rvalid = 1'b1; bus.rdata = 32'hB0 + i;
            #1;
            chk("mr_data", rsp_data, 32'hB0 + i);
            step();
        end
        reset = 1'b1;
        #1;
        step();
        chk("mr_arvalid", bus.arvalid, 0);
        chk("mr_rready", bus.rready, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_req_ready_in_rst", req_ready, 0);
        reset = 1'b0; bus.rvalid = 1'b0;
        #1;
        chk("mr_req_ready_after", req_ready, 1);
        read_single(32'h8000_0040, 32'h5A5A_1234);

        // back-to-back: read then write with req_valid held high
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_4000; req_len = 8'd0;
        req_size = SIZE_4B; bus.arready = 1'b1;
        #1;
        chk("bb_accept_rd", req_ready, 1);
        step();
        req_write = 1'b1; req_addr = 32'h9000_0000; req_wdata = 32'h1122_3344; req_wstrb = 4'hF;
        #1;
        chk("bb_busy_ar", req_ready, 0);
        chk("bb_arvalid", bus.arvalid, 1);
        step();
        bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h77; bus.rlast = 1'b1;
        #1;
        chk("bb_busy_r", req_ready, 0);
        chk("bb_no_aw_yet", bus.awvalid, 0);
        chk("bb_rsp_last", rsp_last, 1);
        step();
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
        #1;
        chk("bb_accept_wr", req_ready, 1);
        step();
        req_valid = 1'b0;
        #1;
        chk("bb_awvalid", bus.awvalid, 1);
        chk("bb_awaddr", bus.awaddr, 32'h9000_0000);
        chk("bb_wdata", bus.wdata, 32'h1122_3344);
        step();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
        #1;
        chk("bb_b_rsp", rsp_valid, 1);
        step();
        bus.bvalid = 1'b0;
        #1;
        chk("bb_back_idle", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
